ultrasonic_ranger: RTL

//  Producer side of the 16-bit `distance` bus consumed by the proximity-alert FSM.

---
 rtl/ultrasonic_ranger.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ultrasonic_ranger.sv
// HC-SR04-style ranger: periodic trigger, echo width timing, conversion to whole cm.
// Optional AVERAGE_EN: 4-entry moving average of valid results (+1 cycle strobe latency).
module ultrasonic_ranger #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = 60,
    parameter int TIMEOUT_US = 25000,
    parameter int DIST_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              echo,
    output logic              trigger,
    output logic [DIST_W-1:0] distance,
    output logic              distance_valid,
    output logic              timeout
);
    localparam int CYC_US     = CLK_HZ / 1_000_000;
    localparam int PERIOD_CYC = PERIOD_MS * 1000 * CYC_US;
    localparam int TRIG_CYC   = TRIG_US * CYC_US;
    localparam int TO_CYC     = TIMEOUT_US * CYC_US;
    localparam int CM_CYC     = 58 * CYC_US;
    localparam int TMAX       = (TO_CYC > TRIG_CYC) ? TO_CYC : TRIG_CYC;
    localparam int PW         = $clog2(PERIOD_CYC);
    localparam int TW         = $clog2(TMAX + 1);
    localparam int CW         = $clog2(CM_CYC);
    localparam logic [DIST_W-1:0] ONES = {DIST_W{1'b1}};
    localparam logic [DIST_W-1:0] SAT  = ONES - DIST_W'(1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, DONE} state_t;

    state_t            r_state;
    logic [PW-1:0]     r_pcnt;
    logic [TW-1:0]     r_tcnt;
    logic [CW-1:0]     r_ccnt;
    logic [DIST_W-1:0] r_cm;
    logic              r_arm;
    logic              r_echo_s1, r_echo_s2, r_echo_s3;

    logic              w_rise, w_fall, w_to_hit, w_wrap, w_sat;
    logic              w_fin, w_fin_to;
    logic [DIST_W-1:0] w_fin_val;

    // Both edges see the same synchroniser delay, so measured width is exact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
            r_echo_s3 <= 1'b0;
        end else begin
            r_echo_s1 <= echo;
            r_echo_s2 <= r_echo_s1;
            r_echo_s3 <= r_echo_s2;
        end
    end

    assign w_rise   = r_echo_s2 & ~r_echo_s3;
    assign w_fall   = ~r_echo_s2 & r_echo_s3;
    assign w_to_hit = (r_tcnt == TW'(TO_CYC - 1));
    assign w_wrap   = (r_ccnt == CW'(CM_CYC - 1));
    assign w_sat    = (r_cm == SAT);

    // The falling-edge cycle is itself an echo-high cycle, so it may complete a cm.
    always_comb begin
        w_fin     = 1'b0;
        w_fin_to  = 1'b0;
        w_fin_val = (w_wrap && !w_sat) ? r_cm + DIST_W'(1) : r_cm;
        case (r_state)
            WAIT_RISE: if (!w_rise && w_to_hit) begin
                w_fin    = 1'b1;
                w_fin_to = 1'b1;
            end
            MEASURE: if (w_fall) begin
                w_fin = 1'b1;
            end else if (w_to_hit) begin
                w_fin    = 1'b1;
                w_fin_to = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef AVERAGE_EN
    logic [DIST_W-1:0]        r_res;
    logic                     r_res_to;
    logic [3:0][DIST_W-1:0]   r_win;
    logic                     r_empty;
    logic [DIST_W+1:0]        w_sum;

    assign w_sum = (DIST_W+2)'(r_res) + (DIST_W+2)'(r_win[0])
                 + (DIST_W+2)'(r_win[1]) + (DIST_W+2)'(r_win[2]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pcnt         <= '0;
            r_tcnt         <= '0;
            r_ccnt         <= '0;
            r_cm           <= '0;
            r_arm          <= 1'b1;
            trigger        <= 1'b0;
            distance       <= ONES;
            distance_valid <= 1'b0;
            timeout        <= 1'b0;
`ifdef AVERAGE_EN
            r_res          <= '0;
            r_res_to       <= 1'b0;
            r_win          <= '0;
            r_empty        <= 1'b1;
`endif
        end else begin
            distance_valid <= 1'b0;
            if (r_pcnt != PW'(PERIOD_CYC - 1))
                r_pcnt <= r_pcnt + PW'(1);
            case (r_state)
                IDLE: begin
                    if (!enable) begin
                        r_arm <= 1'b1;
                    end else if (r_arm || r_pcnt == PW'(PERIOD_CYC - 1)) begin
                        r_state <= TRIG;
                        r_pcnt  <= '0;
                        r_arm   <= 1'b0;
                        r_tcnt  <= '0;
                        trigger <= 1'b1;
                    end
                end
                TRIG: begin
                    if (r_tcnt == TW'(TRIG_CYC - 1)) begin
                        trigger <= 1'b0;
                        r_tcnt  <= '0;
                        r_state <= WAIT_RISE;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                WAIT_RISE: begin
                    if (w_rise) begin
                        r_state <= MEASURE;
                        r_tcnt  <= '0;
                        r_ccnt  <= '0;
                        r_cm    <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                MEASURE: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (w_wrap) begin
                        r_ccnt <= '0;
                        if (!w_sat) r_cm <= r_cm + DIST_W'(1);
                    end else begin
                        r_ccnt <= r_ccnt + CW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
`ifdef AVERAGE_EN
                    distance_valid <= 1'b1;
                    if (r_res_to) begin
                        distance <= ONES;
                        timeout  <= 1'b1;
                        r_empty  <= 1'b1;
                    end else if (r_empty) begin
                        r_win    <= {4{r_res}};
                        distance <= r_res;
                        timeout  <= 1'b0;
                        r_empty  <= 1'b0;
                    end else begin
                        r_win    <= {r_win[2:0], r_res};
                        distance <= w_sum[DIST_W+1:2];
                        timeout  <= 1'b0;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
            if (w_fin) begin
                r_state <= DONE;
`ifdef AVERAGE_EN
                r_res    <= w_fin_to ? ONES : w_fin_val;
                r_res_to <= w_fin_to;
`else
                distance       <= w_fin_to ? ONES : w_fin_val;
                timeout        <= w_fin_to;
                distance_valid <= 1'b1;
`endif
            end
        end
    end
endmodule
